dmem_handshake: RTL and testbench

- Memory-stage responder for the decoded memory controls (load, store, load-byte) produced by the pipeline controller.
- Converts each M-stage load/store into a req/ack transaction on a variable-latency data-memory port.
- Freezes the pipeline with `stallM` until the transaction completes.
- Returns load data to the M/W pipeline register, with lb byte select and sign-extension already applied.

---
 rtl/dmem_handshake_pkg.sv | 20 ++
 rtl/dmem_handshake_if.sv | 22 ++
 rtl/dmem_handshake_lb_extract.sv | 15 +
 rtl/dmem_handshake.sv | 139 +++++++++++++
 tb/tb_dmem_handshake.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_handshake_pkg.sv
// rtl/dmem_handshake_pkg.sv - shared types, constants and lb helper for the memory-stage responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // Load result substituted when the memory never acknowledges
    localparam logic [31:0] DMEM_ERR_DATA = 32'hDEADBEEF;

    // Little-endian byte select followed by sign-extension to a full word
    function automatic logic [31:0] byte_sext(input logic [31:0] word, input logic [1:0] off);
        logic [7:0] b;
        b = word[{off, 3'b000} +: 8];
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/dmem_handshake_if.sv
// rtl/dmem_handshake_if.sv - req/ack data-memory port bundle
interface dmem_handshake_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          memreq;
    logic          memwe;
    logic [AW-1:0] memaddr;
    logic [DW-1:0] memwdata;
    logic [DW-1:0] memrdata;
    logic          memack;

    modport master (
        output memreq, memwe, memaddr, memwdata,
        input  memrdata, memack
    );

    modport slave (
        input  memreq, memwe, memaddr, memwdata,
        output memrdata, memack
    );
endinterface

// File: rtl/dmem_handshake_lb_extract.sv
// rtl/dmem_handshake_lb_extract.sv - combinational lb byte select and sign-extension
module lb_extract
    import dmem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] i_word,
    input  logic [1:0]    i_off,
    output logic [DW-1:0] o_data
);

    // The signed cast keeps the sign bit propagating if the bus is wider than a word
    assign o_data = DW'($signed(byte_sext(i_word[31:0], i_off)));

endmodule

// File: rtl/dmem_handshake.sv
// rtl/dmem_handshake.sv - M-stage load/store to req/ack memory responder (optional MEM_TIMEOUT_EN)
module dmem_handshake
    import dmem_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 32,
    parameter int WAIT_MAX = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                memtoregM,
    input  logic                memwriteM,
    input  logic                lbM,
    input  logic [AW-1:0]       aluoutM,
    input  logic [DW-1:0]       writedataM,
    output logic                stallM,
    output logic [DW-1:0]       readdataM,
    output logic                memerr,
    dmem_handshake_if.master    mem
);

    dmem_state_t   r_state;
    logic          r_memreq;
    logic          r_memwe;
    logic [AW-1:0] r_memaddr;
    logic [DW-1:0] r_memwdata;
    logic [DW-1:0] r_readdata;
    logic          r_load;
    logic          r_lb;
    logic [1:0]    r_off;

    logic          w_access;
    logic          w_timeout;
    logic [DW-1:0] w_lb_data;

    assign w_access = memtoregM | memwriteM;

    // Freeze as soon as an access is seen in IDLE, and for every REQ cycle; DONE lets M advance
    assign stallM = ((r_state == IDLE) && w_access) || (r_state == REQ);

    assign mem.memreq   = r_memreq;
    assign mem.memwe    = r_memwe;
    assign mem.memaddr  = r_memaddr;
    assign mem.memwdata = r_memwdata;
    assign readdataM    = r_readdata;

    lb_extract #(.DW(DW)) u_lb_extract (
        .i_word (mem.memrdata),
        .i_off  (r_off),
        .o_data (w_lb_data)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    logic [CW-1:0] r_wait_cnt;
    logic          r_memerr;

    // Give up in the REQ cycle that would bring the unacknowledged count to WAIT_MAX
    assign w_timeout = (r_state == REQ) && !mem.memack && (r_wait_cnt == CW'(WAIT_MAX - 1));
    assign memerr    = r_memerr;

    // Count unacknowledged REQ cycles and pulse memerr for the DONE cycle a timeout produces
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
            r_memerr   <= 1'b0;
        end else begin
            r_memerr <= w_timeout;
            if ((r_state == IDLE) && w_access) begin
                r_wait_cnt <= '0;
            end else if ((r_state == REQ) && !mem.memack) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end
`else
    wire w_unused_wait_max = (WAIT_MAX != 0);

    assign w_timeout = 1'b0;
    assign memerr    = 1'b0;
`endif

    // Transaction FSM: latch the access in IDLE, hold the request until ack, one DONE cycle to advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_memreq   <= 1'b0;
            r_memwe    <= 1'b0;
            r_memaddr  <= '0;
            r_memwdata <= '0;
            r_readdata <= '0;
            r_load     <= 1'b0;
            r_lb       <= 1'b0;
            r_off      <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        r_state    <= REQ;
                        r_memreq   <= 1'b1;
                        r_memwe    <= memwriteM;
                        r_memaddr  <= {aluoutM[AW-1:2], 2'b00};
                        r_memwdata <= writedataM;
                        r_load     <= memtoregM & ~memwriteM;
                        r_lb       <= lbM & ~memwriteM;
                        r_off      <= aluoutM[1:0];
                    end
                end
                REQ: begin
                    if (mem.memack) begin
                        r_state  <= DONE;
                        r_memreq <= 1'b0;
                        r_memwe  <= 1'b0;
                        if (r_load) begin
                            r_readdata <= r_lb ? w_lb_data : mem.memrdata;
                        end
                    end else if (w_timeout) begin
                        r_state  <= DONE;
                        r_memreq <= 1'b0;
                        r_memwe  <= 1'b0;
                        if (r_load) begin
                            r_readdata <= DW'(DMEM_ERR_DATA);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state  <= IDLE;
                    r_memreq <= 1'b0;
                    r_memwe  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_handshake.sv
// tb/tb_dmem_handshake.sv - scoreboard bench for dmem_handshake with randomized loads/stores
module tb_dmem_handshake;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int WMAX = 4;

    localparam int OP_LW   = 0;
    localparam int OP_LB   = 1;
    localparam int OP_SW   = 2;
    localparam int OP_BOTH = 3;
    localparam int OP_NONE = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          memtoregM = 1'b0;
    logic          memwriteM = 1'b0;
    logic          lbM = 1'b0;
    logic [AW-1:0] aluoutM = '0;
    logic [DW-1:0] writedataM = '0;
    logic          stallM;
    logic [DW-1:0] readdataM;
    logic          memerr;

    logic          ack_norm = 1'b0;
    logic          rst_ack = 1'b0;
    logic [DW-1:0] rdata_drv = '0;

    dmem_handshake_if #(.AW(AW), .DW(DW)) mem_if ();

    assign mem_if.memack   = ack_norm | rst_ack;
    assign mem_if.memrdata = rdata_drv;

    dmem_handshake #(.DW(DW), .AW(AW), .WAIT_MAX(WMAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .memtoregM  (memtoregM),
        .memwriteM  (memwriteM),
        .lbM        (lbM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .stallM     (stallM),
        .readdataM  (readdataM),
        .memerr     (memerr),
        .mem        (mem_if)
    );

    typedef struct { logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata; } req_t;
    typedef struct { logic [DW-1:0] rd; logic err; } done_t;
    typedef struct { logic [DW-1:0] rdata; int delay; } mem_t;

    req_t  req_q[$];
    done_t done_q[$];
    mem_t  mem_q[$];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_rd = '0;
    bit          pause = 1'b0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference lb: pick byte (addr mod 4) of the word, interpret as signed -128..127
    function automatic logic [31:0] ref_lb(input logic [31:0] w, input logic [31:0] a);
        int b;
        b = int'((w >> (8 * (a % 4))) & 32'hFF);
        if (b > 127) b = b - 256;
        return 32'(b);
    endfunction

    task automatic drive(input int op, input logic [31:0] addr, input logic [31:0] wdata, input bit lb_rand);
        memtoregM  = (op == OP_LW) || (op == OP_LB) || (op == OP_BOTH);
        memwriteM  = (op == OP_SW) || (op == OP_BOTH);
        lbM        = (op == OP_LB) || (((op == OP_BOTH) || (op == OP_NONE)) && lb_rand);
        aluoutM    = addr;
        writedataM = wdata;
    endtask

    // Issue one M-stage instruction, queue its expectations and check the stall length
    task automatic issue(input int op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int delay, input bit tmo);
        bit is_ld, is_st;
        int st, exp_st;
        is_st = (op == OP_SW) || (op == OP_BOTH);
        is_ld = ((op == OP_LW) || (op == OP_LB)) && !is_st;
        if (op == OP_NONE) begin
            drive(op, addr, wdata, $urandom_range(1));
            @(negedge clk);
            check("nomem_stall", stallM, 1'b0);
            check("nomem_rd", readdataM, model_rd);
        end else begin
            req_q.push_back('{{addr[31:2], 2'b00}, is_st, wdata});
            if (is_ld) model_rd = tmo ? 32'hDEADBEEF : ((op == OP_LB) ? ref_lb(rdata, addr) : rdata);
            done_q.push_back('{model_rd, tmo});
            mem_q.push_back('{rdata, delay});
            drive(op, addr, wdata, $urandom_range(1));
            exp_st = tmo ? (1 + WMAX) : (delay + 2);
            st = 0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (stallM) st++;
                else break;
            end
            check("stall_cycles", st, exp_st);
        end
        @(posedge clk);
        #1;
    endtask

    // Memory model: acks each request after its queued delay; stray acks when idle
    initial begin
        bit   started = 1'b0;
        int   cnt = 0;
        mem_t m;
        forever begin
            @(negedge clk);
            ack_norm = 1'b0;
            if (pause) begin
                started = 1'b0;
            end else begin
                if (!started && mem_if.memreq) begin
                    if (mem_q.size() == 0) begin
                        check("mem_q_underflow", 1'b1, 1'b0);
                    end else begin
                        m = mem_q.pop_front();
                        cnt = m.delay;
                        started = 1'b1;
                    end
                end
                if (started) begin
                    if (cnt == 0) begin
                        ack_norm  = 1'b1;
                        rdata_drv = m.rdata;
                        started   = 1'b0;
                    end else begin
                        cnt--;
                    end
                end else if (!mem_if.memreq && ($urandom_range(3) == 0)) begin
                    ack_norm  = 1'b1;
                    rdata_drv = $urandom;
                end
            end
        end
    end

    // Monitor: match each request against the scoreboard and each DONE cycle against the load model
    initial begin
        logic prev = 1'b0;
        req_t cur;
        done_t d;
        forever begin
            @(negedge clk);
            if (!pause) begin
                if (mem_if.memreq && !prev) begin
                    if (req_q.size() == 0) begin
                        check("unexpected_req", 1'b1, 1'b0);
                    end else begin
                        cur = req_q.pop_front();
                        check("req_addr", mem_if.memaddr, cur.addr);
                        check("req_we", mem_if.memwe, cur.we);
                        check("req_wdata", mem_if.memwdata, cur.wdata);
                    end
                end else if (mem_if.memreq && prev) begin
                    check("req_stable", {mem_if.memaddr, mem_if.memwe, mem_if.memwdata},
                          {cur.addr, cur.we, cur.wdata});
                end
                if (!mem_if.memreq && prev) begin
                    if (done_q.size() == 0) begin
                        check("unexpected_done", 1'b1, 1'b0);
                    end else begin
                        d = done_q.pop_front();
                        check("done_readdata", readdataM, d.rd);
                        check("done_memerr", memerr, d.err);
                        check("done_stall", stallM, 1'b0);
                    end
                end else begin
                    check("memerr_idle", memerr, 1'b0);
                end
            end
            prev = mem_if.memreq;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        int op;
        logic [31:0] a;

        pause = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_memreq", mem_if.memreq, 1'b0);
        check("rst_memwe", mem_if.memwe, 1'b0);
        check("rst_memaddr", mem_if.memaddr, 32'h0);
        check("rst_memwdata", mem_if.memwdata, 32'h0);
        check("rst_readdata", readdataM, 32'h0);
        check("rst_memerr", memerr, 1'b0);
        check("rst_stall", stallM, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        pause = 1'b0;

        issue(OP_LW, 32'h10, 32'h0, 32'h12345678, 0, 1'b0);
        issue(OP_LB, 32'h13, 32'h0, 32'h80FF7F01, 2, 1'b0);
        issue(OP_SW, 32'h22, 32'hCAFEF00D, 32'h5555AAAA, 0, 1'b0);
        issue(OP_LW, 32'h44, 32'h0, 32'h0BADF00D, 0, 1'b0);
        issue(OP_SW, 32'h48, 32'h13572468, 32'h0, 0, 1'b0);
        issue(OP_BOTH, 32'h57, 32'h11223344, 32'h99887766, 1, 1'b0);
        issue(OP_NONE, 32'h0, 32'h0, 32'h0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(4);
            issue(op, $urandom, $urandom, $urandom, $urandom_range(3), 1'b0);
        end

        // Reset mid-REQ with an ack in the same cycle
        a = $urandom;
        req_q.push_back('{{a[31:2], 2'b00}, 1'b0, 32'h0});
        mem_q.push_back('{32'hFFFFFFFF, 1000});
        drive(OP_LW, a, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        pause   = 1'b1;
        rst_ack = 1'b1;
        reset   = 1'b0;
        drive(OP_NONE, 32'h0, 32'h0, 1'b0);
        #1;
        check("midreset_memreq", mem_if.memreq, 1'b0);
        check("midreset_readdata", readdataM, 32'h0);
        check("midreset_idle", stallM, 1'b0);
        @(posedge clk);
        #1;
        rst_ack = 1'b0;
        reset   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("postreset_noreq", mem_if.memreq, 1'b0);
            check("postreset_rd", readdataM, 32'h0);
        end
        mem_q.delete();
        req_q.delete();
        done_q.delete();
        model_rd = '0;
        @(posedge clk);
        #1;
        pause = 1'b0;

        for (int i = 0; i < 15; i++) begin
            op = $urandom_range(4);
            issue(op, $urandom, $urandom, $urandom, $urandom_range(3), 1'b0);
        end

`ifdef MEM_TIMEOUT_EN
        issue(OP_LW, 32'h80, 32'h0, 32'h1, 1000, 1'b1);
`else
        a = 32'h84;
        req_q.push_back('{a, 1'b0, 32'h0});
        mem_q.push_back('{32'h1, 1000});
        drive(OP_LW, a, 32'h0, 1'b0);
        begin
            int held = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (stallM && mem_if.memreq) held++;
            end
            check("no_timeout_stall", held, 39);
        end
        @(posedge clk);
        #1;
        pause = 1'b1;
        reset = 1'b0;
        drive(OP_NONE, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_q.delete();
`endif
        repeat (3) @(negedge clk);
        check("end_req_q", req_q.size(), 0);
        check("end_done_q", done_q.size(), 0);
        check("end_mem_q", mem_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
